// File: rtl/oam_dma.sv
// Sprite DMA: a CPU write to DMA_REG stalls the CPU and copies page {PAGE,00..FF} to OAM_PORT.
// Optional macro OAMDMA_ALIGN_EN adds the odd-cycle ALIGN state (513/514 stall); otherwise 513.
module oam_dma #(
  parameter logic [15:0] DMA_REG  = 16'h4014,
  parameter logic [15:0] OAM_PORT = 16'h2004
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] CPU_ADDR,
  input  logic [15:0] CPU_EAWR,
  input  logic [7:0]  CPU_DOUT,
  input  logic        CPU_WREQ,
  input  logic        CPU_RD,
  output logic        CE,
  output logic [15:0] BUS_ADDR,
  input  logic [7:0]  BUS_DIN,
  output logic [15:0] BUS_WADDR,
  output logic [7:0]  BUS_WDATA,
  output logic        BUS_WREQ,
  output logic        BUS_RD,
  output logic        BUSY
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] page, idx, lat;
  logic       trig;
  logic       align_req;

  assign trig = (state == S_IDLE) && CPU_WREQ && (CPU_EAWR == DMA_REG);

`ifdef OAMDMA_ALIGN_EN
  logic par;

  // Odd/even CPU cycle marker; an odd WAIT costs one extra dummy cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) par <= 1'b0;
    else     par <= ~par;
  end

  assign align_req = par;
`else
  assign align_req = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (trig) state_nxt = S_WAIT;
      S_WAIT:  state_nxt = align_req ? S_ALIGN : S_READ;
      S_ALIGN: state_nxt = S_READ;
      S_READ:  state_nxt = S_WRITE;
      S_WRITE: state_nxt = (idx == 8'hFF) ? S_IDLE : S_READ;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Index wraps within the page; it never carries into PAGE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      page <= 8'h00;
      idx  <= 8'h00;
      lat  <= 8'h00;
    end else begin
      if (trig) begin
        page <= CPU_DOUT;
        idx  <= 8'h00;
      end
      if (state == S_READ)  lat <= BUS_DIN;
      if (state == S_WRITE) idx <= idx + 8'd1;
    end
  end

  always_comb begin
    CE        = (state == S_IDLE);
    BUSY      = (state != S_IDLE);
    BUS_ADDR  = CPU_ADDR;
    BUS_WADDR = CPU_EAWR;
    BUS_WDATA = CPU_DOUT;
    BUS_WREQ  = CPU_WREQ;
    BUS_RD    = CPU_RD;
    if (state != S_IDLE) begin
      BUS_ADDR  = {page, idx};
      BUS_WADDR = OAM_PORT;
      BUS_WDATA = lat;
      BUS_WREQ  = (state == S_WRITE);
      BUS_RD    = (state == S_WRITE);
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: memory model on BUS_DIN, scoreboard of expected $2004 bytes per transfer.
module tb_oam_dma;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] CPU_ADDR = 16'h0000;
  logic [15:0] CPU_EAWR = 16'h0000;
  logic [7:0]  CPU_DOUT = 8'h00;
  logic        CPU_WREQ = 1'b0;
  logic        CPU_RD = 1'b0;
  logic        CE;
  logic [15:0] BUS_ADDR;
  logic [7:0]  BUS_DIN;
  logic [15:0] BUS_WADDR;
  logic [7:0]  BUS_WDATA;
  logic        BUS_WREQ;
  logic        BUS_RD;
  logic        BUSY;

  oam_dma dut (
    .CLK(CLK), .RST(RST),
    .CPU_ADDR(CPU_ADDR), .CPU_EAWR(CPU_EAWR), .CPU_DOUT(CPU_DOUT),
    .CPU_WREQ(CPU_WREQ), .CPU_RD(CPU_RD),
    .CE(CE), .BUS_ADDR(BUS_ADDR), .BUS_DIN(BUS_DIN),
    .BUS_WADDR(BUS_WADDR), .BUS_WDATA(BUS_WDATA),
    .BUS_WREQ(BUS_WREQ), .BUS_RD(BUS_RD), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  logic [7:0] mem [0:65535];
  assign BUS_DIN = mem[BUS_ADDR];

`ifdef OAMDMA_ALIGN_EN
  localparam int ALIGN_ON = 1;
`else
  localparam int ALIGN_ON = 0;
`endif

  int         errors = 0;
  int         checks = 0;
  int         wr_cnt = 0;
  int         cyc = 0;
  logic [7:0] cur_page = 8'h00;
  logic [7:0] exp_q[$];

  // Edges since reset release; its parity is the CPU cycle parity.
  always @(posedge CLK or posedge RST) begin
    if (RST) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Bus monitor: reads stay inside the page, writes pop the scoreboard.
  always begin
    logic [7:0] e;
    @(negedge CLK);
    #2;
    if (!RST) begin
      checks++;
      if (BUSY !== ~CE) begin
        errors++;
        $display("FAIL busy_vs_ce: BUSY=%b CE=%b", BUSY, CE);
      end
      if (BUSY === 1'b1) begin
        if (BUS_WREQ !== 1'b1) begin
          checks++;
          if (BUS_ADDR[15:8] !== cur_page) begin
            errors++;
            $display("FAIL read_page: addr=%h page=%h", BUS_ADDR, cur_page);
          end
        end else begin
          wr_cnt++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_write: data=%h addr=%h", BUS_WDATA, BUS_WADDR);
          end else begin
            e = exp_q.pop_front();
            if (BUS_WDATA !== e || BUS_WADDR !== 16'h2004 || BUS_RD !== 1'b1) begin
              errors++;
              $display("FAIL oam_write: got %h@%h rd=%b, want %h@2004 rd=1",
                       BUS_WDATA, BUS_WADDR, BUS_RD, e);
            end
          end
        end
      end
    end
  end

  // Issues the $4014 write so that PAR at WAIT equals want_par; returns on the first stall cycle.
  task automatic start_dma(input logic [7:0] page, input int want_par);
    @(negedge CLK);
    while (((cyc + 1) & 1) != want_par) @(negedge CLK);
    CPU_EAWR = 16'h4014;
    CPU_DOUT = page;
    CPU_WREQ = 1'b1;
    cur_page = page;
    for (int i = 0; i < 256; i++) exp_q.push_back(mem[{page, i[7:0]}]);
    #1;
    checks++;
    if (BUS_WREQ !== 1'b1 || BUS_WADDR !== 16'h4014 || BUS_WDATA !== page) begin
      errors++;
      $display("FAIL trig_passthru: wreq=%b waddr=%h wdata=%h", BUS_WREQ, BUS_WADDR, BUS_WDATA);
    end
    @(negedge CLK);
    CPU_WREQ = 1'b0;
    CPU_EAWR = 16'h0000;
  endtask

  // Counts CE-low cycles until CE rises (or stop_at is reached) and the cycle of the first write.
  task automatic measure(input int stop_at, output int n, output int first, output int tmo);
    n = 0; first = 0; tmo = 1;
    for (int k = 0; k < 700; k++) begin
      #1;
      if (CE === 1'b1) begin tmo = 0; break; end
      n++;
      if (BUS_WREQ === 1'b1 && first == 0) first = n;
      if (n == stop_at) begin tmo = 0; break; end
      @(negedge CLK);
    end
  endtask

  task automatic test_reset;
    CPU_ADDR = 16'h1234; CPU_EAWR = 16'h5678; CPU_DOUT = 8'h9A;
    CPU_WREQ = 1'b1; CPU_RD = 1'b1;
    #1;
    checks++;
    if (CE !== 1'b1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: CE=%b BUSY=%b, want 1 0", CE, BUSY);
    end
    checks++;
    if (BUS_ADDR !== 16'h1234 || BUS_WADDR !== 16'h5678 || BUS_WDATA !== 8'h9A ||
        BUS_WREQ !== 1'b1 || BUS_RD !== 1'b1) begin
      errors++;
      $display("FAIL reset_mux: %h %h %h %b %b", BUS_ADDR, BUS_WADDR, BUS_WDATA, BUS_WREQ, BUS_RD);
    end
    @(negedge CLK);
    CPU_WREQ = 1'b0; CPU_RD = 1'b0;
    RST = 1'b0;
  endtask

  task automatic test_transfer(input logic [7:0] page, input int want_par, input int inject);
    int n, first, tmo, w0, exp_n, exp_first;
    exp_n     = 513 + ((ALIGN_ON != 0 && want_par == 1) ? 1 : 0);
    exp_first = 3 + ((ALIGN_ON != 0 && want_par == 1) ? 1 : 0);
    w0 = wr_cnt;
    start_dma(page, want_par);
    if (inject != 0) begin
      // Retrigger attempt and bus noise while busy must be ignored.
      repeat (40) @(negedge CLK);
      CPU_EAWR = 16'h4014; CPU_DOUT = 8'h55; CPU_WREQ = 1'b1; CPU_RD = 1'b1; CPU_ADDR = 16'hBEEF;
      @(negedge CLK);
      CPU_WREQ = 1'b0; CPU_RD = 1'b0; CPU_EAWR = 16'h0000;
    end
    CPU_ADDR = 16'h0C0C;
    measure(0, n, first, tmo);
    if (inject != 0) n = n + 41;
    checks++;
    if (tmo != 0) begin
      errors++;
      $display("FAIL xfer_timeout: page=%h CE never rose", page);
    end
    checks++;
    if (n != exp_n) begin
      errors++;
      $display("FAIL stall_len: page=%h got %0d want %0d", page, n, exp_n);
    end
    if (inject == 0) begin
      checks++;
      if (first != exp_first) begin
        errors++;
        $display("FAIL first_write: got cycle %0d want %0d", first, exp_first);
      end
    end
    checks++;
    if (wr_cnt - w0 != 256 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL write_count: got %0d left %0d want 256 0", wr_cnt - w0, exp_q.size());
    end
    checks++;
    if (BUSY !== 1'b0 || BUS_ADDR !== 16'h0C0C || BUS_WREQ !== 1'b0) begin
      errors++;
      $display("FAIL post_idle_mux: BUSY=%b addr=%h wreq=%b", BUSY, BUS_ADDR, BUS_WREQ);
    end
  endtask

  task automatic test_abort;
    int n, first, tmo, w0;
    start_dma(8'h03, 0);
    measure(100, n, first, tmo);
    RST = 1'b1;
    #1;
    checks++;
    if (CE !== 1'b1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL abort_async: CE=%b BUSY=%b want 1 0", CE, BUSY);
    end
    exp_q.delete();
    @(negedge CLK);
    RST = 1'b0;
    w0 = wr_cnt;
    repeat (10) @(negedge CLK);
    #1;
    checks++;
    if (wr_cnt != w0 || BUSY !== 1'b0 || CE !== 1'b1) begin
      errors++;
      $display("FAIL abort_quiet: writes=%0d BUSY=%b CE=%b", wr_cnt - w0, BUSY, CE);
    end
    test_transfer(8'h03, 1, 0);
  endtask

  task automatic test_idle_writes;
    logic [15:0] addrs [2];
    addrs[0] = 16'h4015;
    addrs[1] = 16'h2004;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      CPU_EAWR = addrs[i]; CPU_DOUT = 8'h3C + i[7:0]; CPU_WREQ = 1'b1;
      CPU_RD = i[0]; CPU_ADDR = 16'h8000 + i[15:0];
      #1;
      checks++;
      if (BUS_WADDR !== addrs[i] || BUS_WDATA !== 8'h3C + i[7:0] || BUS_WREQ !== 1'b1 ||
          BUS_RD !== i[0] || BUS_ADDR !== 16'h8000 + i[15:0]) begin
        errors++;
        $display("FAIL idle_mux: waddr=%h wdata=%h wreq=%b rd=%b addr=%h",
                 BUS_WADDR, BUS_WDATA, BUS_WREQ, BUS_RD, BUS_ADDR);
      end
      @(negedge CLK);
      CPU_WREQ = 1'b0; CPU_RD = 1'b0;
      #1;
      checks++;
      if (CE !== 1'b1 || BUSY !== 1'b0) begin
        errors++;
        $display("FAIL idle_no_dma: addr=%h CE=%b BUSY=%b", addrs[i], CE, BUSY);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = i[7:0];
    mem[16'hFFFF] = 8'hA5;
    test_reset();
    test_transfer(8'h02, 0, 0);
    test_transfer(8'h02, 1, 0);
    test_transfer(8'hFF, 0, 0);
    test_transfer(8'h20, 1, 1);
    test_abort();
    test_idle_writes();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
